// File: rtl/uldl_link_scheduler.sv
// Uplink/downlink packet scheduler: two per-direction FIFOs, weighted round-robin
// arbitration gated by a visibility window, and a ready/valid output register.
// Optional drop statistics counter enabled by defining ULDL_SCHED_STATS_EN.
module uldl_link_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ena,
    input  logic       i_pkt_pulse,
    input  logic [7:0] i_pkt_id,
    input  logic       i_pkt_dir_dl,
    input  logic [1:0] i_wgt_ul,
    input  logic [1:0] i_wgt_dl,
    input  logic       i_win_open,
    input  logic       i_tx_ready,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_id,
    output logic       o_tx_dir_dl,
    output logic [2:0] o_ul_count,
    output logic [2:0] o_dl_count,
    output logic       o_drop_pulse,
    output logic [7:0] o_drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, SERVE_UL, SERVE_DL} state_t;

    logic [7:0]    mem_ul [DEPTH];
    logic [7:0]    mem_dl [DEPTH];
    logic [PW-1:0] wp_ul, rp_ul, wp_dl, rp_dl;
    logic [CW-1:0] cnt_ul, cnt_dl;
    state_t        state;
    logic [1:0]    credit;
    logic          last_dl;

    logic       ul_ne, dl_ne, full_ul, full_dl;
    logic       push_ul, push_dl, pop_ul, pop_dl, wr_ul, wr_dl;
    logic       load, drop;
    logic [1:0] wgt_ul_eff, wgt_dl_eff, wgt_sel, credit_ld;
    logic       sel_dl, fresh;

    assign ul_ne      = (cnt_ul != '0);
    assign dl_ne      = (cnt_dl != '0);
    assign full_ul    = (cnt_ul == CW'(DEPTH));
    assign full_dl    = (cnt_dl == CW'(DEPTH));
    assign wgt_ul_eff = (i_wgt_ul == 2'd0) ? 2'd1 : i_wgt_ul;
    assign wgt_dl_eff = (i_wgt_dl == 2'd0) ? 2'd1 : i_wgt_dl;

    // Grant selection: fresh means the served direction starts a new turn with full credit
    always_comb begin
        sel_dl = 1'b0;
        fresh  = 1'b1;
        case (state)
            IDLE: sel_dl = last_dl ? !ul_ne : dl_ne;
            SERVE_UL: begin
                if (!ul_ne) begin
                    sel_dl = 1'b1;
                end else if (credit == 2'd0) begin
                    sel_dl = dl_ne;
                end else begin
                    fresh = 1'b0;
                end
            end
            SERVE_DL: begin
                sel_dl = 1'b1;
                if (!dl_ne) begin
                    sel_dl = 1'b0;
                end else if (credit == 2'd0) begin
                    sel_dl = !ul_ne;
                end else begin
                    fresh = 1'b0;
                end
            end
            default: sel_dl = 1'b0;
        endcase
    end

    assign wgt_sel   = sel_dl ? wgt_dl_eff : wgt_ul_eff;
    assign credit_ld = (fresh ? wgt_sel : credit) - 2'd1;

    assign load    = i_ena && i_win_open && (!o_tx_valid || i_tx_ready) && (ul_ne || dl_ne);
    assign pop_ul  = load && !sel_dl;
    assign pop_dl  = load && sel_dl;
    assign push_ul = i_ena && i_pkt_pulse && !i_pkt_dir_dl;
    assign push_dl = i_ena && i_pkt_pulse && i_pkt_dir_dl;
    assign wr_ul   = push_ul && (!full_ul || pop_ul);
    assign wr_dl   = push_dl && (!full_dl || pop_dl);
    assign drop    = (push_ul && full_ul && !pop_ul) || (push_dl && full_dl && !pop_dl);

    // Queue storage, no reset needed: occupancy qualifies every entry
    always_ff @(posedge i_clk) begin
        if (wr_ul) mem_ul[wp_ul] <= i_pkt_id;
        if (wr_dl) mem_dl[wp_dl] <= i_pkt_id;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_ul  <= '0;
            rp_ul  <= '0;
            cnt_ul <= '0;
            wp_dl  <= '0;
            rp_dl  <= '0;
            cnt_dl <= '0;
        end else if (!i_ena) begin
            wp_ul  <= '0;
            rp_ul  <= '0;
            cnt_ul <= '0;
            wp_dl  <= '0;
            rp_dl  <= '0;
            cnt_dl <= '0;
        end else begin
            if (wr_ul)  wp_ul <= wp_ul + PW'(1);
            if (pop_ul) rp_ul <= rp_ul + PW'(1);
            if (wr_dl)  wp_dl <= wp_dl + PW'(1);
            if (pop_dl) rp_dl <= rp_dl + PW'(1);
            cnt_ul <= cnt_ul + CW'(wr_ul) - CW'(pop_ul);
            cnt_dl <= cnt_dl + CW'(wr_dl) - CW'(pop_dl);
        end
    end

    // Arbitration state and output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            credit       <= 2'd0;
            last_dl      <= 1'b1;
            o_tx_valid   <= 1'b0;
            o_tx_id      <= 8'h00;
            o_tx_dir_dl  <= 1'b0;
            o_drop_pulse <= 1'b0;
        end else begin
            o_drop_pulse <= drop;
            if (!i_ena) begin
                state      <= IDLE;
                credit     <= 2'd0;
                o_tx_valid <= 1'b0;
            end else if (load) begin
                state       <= sel_dl ? SERVE_DL : SERVE_UL;
                credit      <= credit_ld;
                last_dl     <= sel_dl;
                o_tx_valid  <= 1'b1;
                o_tx_id     <= sel_dl ? mem_dl[rp_dl] : mem_ul[rp_ul];
                o_tx_dir_dl <= sel_dl;
            end else begin
                if (o_tx_valid && i_tx_ready) o_tx_valid <= 1'b0;
                if (state == SERVE_UL && !ul_ne) begin
                    state  <= dl_ne ? SERVE_DL : IDLE;
                    credit <= dl_ne ? wgt_dl_eff : 2'd0;
                end else if (state == SERVE_DL && !dl_ne) begin
                    state  <= ul_ne ? SERVE_UL : IDLE;
                    credit <= ul_ne ? wgt_ul_eff : 2'd0;
                end
            end
        end
    end

    assign o_ul_count = cnt_ul;
    assign o_dl_count = cnt_dl;

`ifdef ULDL_SCHED_STATS_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt <= 8'h00;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uldl_link_scheduler.sv
// Directed testbench for uldl_link_scheduler: latency, weighted order, drops,
// backpressure, flush and asynchronous reset.
module tb_uldl_link_scheduler;

    logic       clk, rst_n, ena, pkt_pulse, pkt_dir_dl, win_open, tx_ready;
    logic [7:0] pkt_id;
    logic [1:0] wgt_ul, wgt_dl;
    logic       tx_valid, tx_dir_dl, drop_pulse;
    logic [7:0] tx_id, drop_cnt;
    logic [2:0] ul_count, dl_count;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [7:0] EXP_DROP1 =
`ifdef ULDL_SCHED_STATS_EN
        8'd1;
`else
        8'd0;
`endif

    uldl_link_scheduler #(.DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ena        (ena),
        .i_pkt_pulse  (pkt_pulse),
        .i_pkt_id     (pkt_id),
        .i_pkt_dir_dl (pkt_dir_dl),
        .i_wgt_ul     (wgt_ul),
        .i_wgt_dl     (wgt_dl),
        .i_win_open   (win_open),
        .i_tx_ready   (tx_ready),
        .o_tx_valid   (tx_valid),
        .o_tx_id      (tx_id),
        .o_tx_dir_dl  (tx_dir_dl),
        .o_ul_count   (ul_count),
        .o_dl_count   (dl_count),
        .o_drop_pulse (drop_pulse),
        .o_drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pkt_pulse = 1'b0;
        tick();
        rst_n = 1'b1;
        ena = 1'b1;
    endtask

    task automatic push(input logic [7:0] id, input logic dl);
        pkt_pulse  = 1'b1;
        pkt_id     = id;
        pkt_dir_dl = dl;
        tick();
        pkt_pulse  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_id"},    32'(tx_id),    32'h00);
        chk({tag, "_dir"},   32'(tx_dir_dl), 32'd0);
        chk({tag, "_ulc"},   32'(ul_count), 32'd0);
        chk({tag, "_dlc"},   32'(dl_count), 32'd0);
        chk({tag, "_dp"},    32'(drop_pulse), 32'd0);
        chk({tag, "_dc"},    32'(drop_cnt), 32'd0);
    endtask

    logic       exp_dir [8];
    logic [7:0] exp_id  [8];

    initial begin
        rst_n = 1'b0; ena = 1'b0; pkt_pulse = 1'b0; pkt_id = 8'h00; pkt_dir_dl = 1'b0;
        wgt_ul = 2'd2; wgt_dl = 2'd1; win_open = 1'b1; tx_ready = 1'b1;
        #12;
        chk_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        ena = 1'b1;

        // Single UL packet latency
        push(8'h3C, 1'b0);
        chk("lat_k_valid", 32'(tx_valid), 32'd0);
        chk("lat_k_ulc", 32'(ul_count), 32'd1);
        tick();
        chk("lat_valid", 32'(tx_valid), 32'd1);
        chk("lat_id", 32'(tx_id), 32'h3C);
        chk("lat_dir", 32'(tx_dir_dl), 32'd0);
        chk("lat_ulc", 32'(ul_count), 32'd0);
        tick();
        chk("lat_done", 32'(tx_valid), 32'd0);

        // Weighted round robin 2:1
        do_reset();
        win_open = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1'b1);
        chk("wrr_ulc", 32'(ul_count), 32'd4);
        chk("wrr_dlc", 32'(dl_count), 32'd4);
        chk("wrr_novalid", 32'(tx_valid), 32'd0);
        exp_dir = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_id  = '{8'h10, 8'h11, 8'h20, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
        win_open = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("wrr_v%0d", i), 32'(tx_valid), 32'd1);
            chk($sformatf("wrr_d%0d", i), 32'(tx_dir_dl), 32'(exp_dir[i]));
            chk($sformatf("wrr_i%0d", i), 32'(tx_id), 32'(exp_id[i]));
        end
        tick();
        chk("wrr_end", 32'(tx_valid), 32'd0);

        // Overflow with window closed, then push+pop on a full queue
        do_reset();
        win_open = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(8'h30 + 8'(i), 1'b0);
            chk($sformatf("ovf_dp%0d", i), 32'(drop_pulse), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("ovf_ulc", 32'(ul_count), 32'd4);
        chk("ovf_cnt", 32'(drop_cnt), 32'(EXP_DROP1));
        tick();
        chk("ovf_dp_once", 32'(drop_pulse), 32'd0);
        win_open = 1'b1;
        push(8'h55, 1'b0);
        chk("pp_ulc", 32'(ul_count), 32'd4);
        chk("pp_dp", 32'(drop_pulse), 32'd0);
        chk("pp_id", 32'(tx_id), 32'h30);
        chk("pp_cnt", 32'(drop_cnt), 32'(EXP_DROP1));

        // Backpressure and window closure
        do_reset();
        win_open = 1'b1;
        tx_ready = 1'b0;
        push(8'h41, 1'b0);
        push(8'h42, 1'b1);
        chk("bp_valid0", 32'(tx_valid), 32'd1);
        win_open = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_id%0d", i), 32'(tx_id), 32'h41);
            chk($sformatf("bp_dir%0d", i), 32'(tx_dir_dl), 32'd0);
            chk($sformatf("bp_v%0d", i), 32'(tx_valid), 32'd1);
        end
        tx_ready = 1'b1;
        tick();
        chk("bp_accept", 32'(tx_valid), 32'd0);
        chk("bp_dlc", 32'(dl_count), 32'd1);
        tick();
        chk("bp_noload", 32'(tx_valid), 32'd0);

        // Flush with queued packets and a packet in flight
        do_reset();
        win_open = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i), 1'b0);
        win_open = 1'b1;
        tx_ready = 1'b0;
        tick();
        chk("fl_valid", 32'(tx_valid), 32'd1);
        chk("fl_ulc3", 32'(ul_count), 32'd3);
        ena = 1'b0;
        push(8'h77, 1'b0);
        chk("fl_ulc", 32'(ul_count), 32'd0);
        chk("fl_dlc", 32'(dl_count), 32'd0);
        chk("fl_v", 32'(tx_valid), 32'd0);
        ena = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fl_stale%0d", i), 32'(tx_valid), 32'd0);
        end

        // Asynchronous reset mid-burst
        do_reset();
        win_open = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h81 + 8'(i), 1'b0);
        win_open = 1'b1;
        tick();
        chk("ar_pre_valid", 32'(tx_valid), 32'd1);
        chk("ar_pre_id", 32'(tx_id), 32'h81);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("ar");
        tick();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uldl_link_scheduler.md
ULDL_LINK_SCHEDULER -- requirements
Module: uldl_link_scheduler

Interface
REQ-001 SHALL have parameter: DEPTH, default 4, per-direction queue depth in packets; legal values 2 or 4.
REQ-002 SHALL have port: i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: i_ena  input  1  block enable; low acts as synchronous flush.
REQ-005 SHALL have port: i_pkt_pulse  input  1  one-cycle new-packet strobe from the traffic generator.
REQ-006 SHALL have port: i_pkt_id  input  8  packet ID, valid with i_pkt_pulse.
REQ-007 SHALL have port: i_pkt_dir_dl  input  1  packet direction, 0=UL, 1=DL, valid with i_pkt_pulse.
REQ-008 SHALL have port: i_wgt_ul  input  2  consecutive UL grants per turn when DL is also pending; 0 treated as 1.
REQ-009 SHALL have port: i_wgt_dl  input  2  consecutive DL grants per turn when UL is also pending; 0 treated as 1.
REQ-010 SHALL have port: i_win_open  input  1  satellite visibility window; high permits new transmissions.
REQ-011 SHALL have port: i_tx_ready  input  1  link accepts the current output packet.
REQ-012 SHALL have port: o_tx_valid  output  1  output packet valid.
REQ-013 SHALL have port: o_tx_id  output  8  output packet ID.
REQ-014 SHALL have port: o_tx_dir_dl  output  1  output packet direction.
REQ-015 SHALL have port: o_ul_count  output  3  UL queue occupancy.
REQ-016 SHALL have port: o_dl_count  output  3  DL queue occupancy.
REQ-017 SHALL have port: o_drop_pulse  output  1  one-cycle strobe when a packet is dropped on a full queue.
REQ-018 SHALL have port: o_drop_cnt  output  8  saturating count of dropped packets.

Function
REQ-019 SHALL, when i_ena=1 and i_pkt_pulse=1, write i_pkt_id into the UL or DL FIFO selected by i_pkt_dir_dl at that edge.
REQ-020 SHALL discard the packet when its queue is full and not popped in the same cycle, and SHALL assert o_drop_pulse for exactly the following cycle.
REQ-021 SHALL perform a push and a pop on the same queue in the same cycle, including on a full queue, without a drop and with occupancy unchanged.
REQ-022 SHALL hold o_tx_id/o_tx_dir_dl stable while o_tx_valid=1 and i_tx_ready=0; a transfer completes on any edge where both are 1.
REQ-023 SHALL load the output register from the granted queue head when it is empty or completing a transfer, i_win_open=1, and i_ena=1, sustaining one packet per cycle.
REQ-024 SHALL give latency: pulse sampled at edge k into an empty system with window open -> o_tx_valid=1 after edge k+1.
REQ-025 SHALL run FSM states IDLE, SERVE_UL, SERVE_DL with a credit counter loaded from the serving direction's weight, where 0 is treated as 1.
REQ-026 SHALL, in IDLE, enter the direction opposite to the last-served direction if that queue is non-empty, otherwise the other non-empty queue.
REQ-027 SHALL, in SERVE_x, decrement credit on each grant and switch to the other direction, reloading credit, when credit reaches 0 and the other queue is non-empty.
REQ-028 SHALL, in SERVE_x, when its own queue is empty, switch to the other direction if that queue is non-empty, else go to IDLE.
REQ-029 SHALL keep granting a lone non-empty direction regardless of credit, reloading credit.
REQ-030 SHALL, with i_win_open=0, make no new loads, keep any packet already in the output register valid until accepted, and continue queueing.
REQ-031 SHALL, with i_ena=0, empty both queues, clear o_tx_valid, enter IDLE, and ignore i_pkt_pulse, including mid-transfer.

Reset
REQ-032 SHALL on reset set o_tx_valid=0, o_tx_id=8'h00, o_tx_dir_dl=0, both counts=0, o_drop_pulse=0, o_drop_cnt=0, FSM=IDLE, credit=0, last-served=DL so that UL is served first.

Configuration
REQ-033 SHALL, with ULDL_SCHED_STATS_EN defined, make o_drop_cnt increment on each drop, saturate at 255, and clear only on reset.
REQ-034 SHALL, without ULDL_SCHED_STATS_EN, tie o_drop_cnt to 8'h00 and omit the counter logic, with no other behavioural change.

Verification
REQ-035 SHALL cover: single UL pulse id 8'h3C, window open, ready=1 -> o_tx_valid high for 1 cycle two edges after pulse with id 8'h3C and dir 0.
REQ-036 SHALL cover: preload UL 4 and DL 4, i_wgt_ul=2, i_wgt_dl=1, then open window with ready=1 -> dir order 0,0,1,0,0,1,1,1.
REQ-037 SHALL cover: 5 UL pulses with window closed and DEPTH=4 -> o_ul_count=4, one o_drop_pulse, o_drop_cnt=1 with macro and 0 without.
REQ-038 SHALL cover: ready held 0 for 3 cycles with valid high -> id and dir stable; window closed meanwhile -> packet still delivered, no further loads.
REQ-039 SHALL cover: i_ena deasserted with 3 queued packets and valid high -> next cycle counts=0 and valid=0; re-enable -> no stale packet emitted.
REQ-040 SHALL cover: reset asserted mid-burst -> all outputs at reset values immediately, asynchronously to i_clk.
